esc_fault_supervisor: RTL and testbench

Parametrised successor to the single-bit PWM kill path. Takes N_SRC raw trip sources (gate-driver fault, encoder illegal, timing fault, MMCM unlock, power-good loss, bus over/under-voltage, ...) and processes each one:
- synchronises it into clk_ctrl;
- runs it through a per-channel glitch filter;
- gates it with a per-channel mask.

A four-state arm/run/fault sequencer drives run_en to the PWM stage. Reports sticky per-channel fault status and first-fault index to the PS.

---
 rtl/esc_fault_supervisor.sv | 175 +++++++++++++++++
 tb/tb_esc_fault_supervisor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_fault_supervisor.sv
// Trip supervisor: per-channel sync + glitch filter + mask feeding an arm/run/fault sequencer.
// Optional macro ESC_FAULT_TIMESTAMP_EN adds a free-running cycle counter captured on first fault.

module esc_trip_filter #(
  parameter int FILT_CYC = 3
) (
  input  logic clk_ctrl,
  input  logic rst_ctrl,
  input  logic raw,
  input  logic mask,
  output logic qual
);
  localparam int CNT_W = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);

  (* ASYNC_REG = "TRUE" *) logic sync1;
  (* ASYNC_REG = "TRUE" *) logic sync2;
  logic [CNT_W-1:0] cnt;
  logic             act;

  assign act = sync2 && mask;

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!act)
        cnt <= '0;
      else if (cnt != CNT_W'(FILT_CYC))
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Gating with act makes release immediate: a stale saturated count never qualifies.
  assign qual = act && (cnt == CNT_W'(FILT_CYC));
endmodule

module esc_fault_supervisor #(
  parameter int N_SRC    = 8,
  parameter int FILT_CYC = 3,
  parameter int ARM_DLY  = 16,
  parameter int IDX_W    = $clog2(N_SRC)
) (
  input  logic             clk_ctrl,
  input  logic             rst_ctrl,
  input  logic [N_SRC-1:0] trip_raw,
  input  logic [N_SRC-1:0] trip_mask,
  input  logic             sw_enable,
  input  logic             sw_clear_fault,
  output logic             run_en,
  output logic             fault_latched,
  output logic [N_SRC-1:0] fault_vec,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_valid,
  output logic [1:0]       state,
  output logic [31:0]      fault_ts
);
  localparam int ARM_W = (ARM_DLY < 2) ? 1 : $clog2(ARM_DLY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           st;
  logic [N_SRC-1:0] qual;
  logic             trip_any;
  logic [IDX_W-1:0] first_nxt;
  logic [ARM_W-1:0] arm_cnt;
  logic             sw_en_q;
  logic             clr_ok;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ch
    esc_trip_filter #(.FILT_CYC(FILT_CYC)) u_filt (
      .clk_ctrl (clk_ctrl),
      .rst_ctrl (rst_ctrl),
      .raw      (trip_raw[gi]),
      .mask     (trip_mask[gi]),
      .qual     (qual[gi])
    );
  end

  assign trip_any = |qual;

  // Descending scan so the lowest qualifying index is the final assignment.
  always_comb begin
    first_nxt = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (qual[i]) first_nxt = IDX_W'(i);
  end

  assign clr_ok = (st == FAULT) && sw_clear_fault && !trip_any;

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      st          <= IDLE;
      arm_cnt     <= '0;
      sw_en_q     <= 1'b0;
      fault_vec   <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else begin
      sw_en_q <= sw_enable;
      if (trip_any) begin
        // Trip capture wins over every other request, from any state.
        st        <= FAULT;
        arm_cnt   <= '0;
        fault_vec <= fault_vec | qual;
        if (!first_valid) begin
          first_valid <= 1'b1;
          first_idx   <= first_nxt;
        end
      end else begin
        case (st)
          IDLE:
            if (sw_enable && !sw_en_q) begin
              st      <= ARMING;
              arm_cnt <= '0;
            end
          ARMING:
            if (!sw_enable) begin
              st      <= IDLE;
              arm_cnt <= '0;
            end else if (arm_cnt == ARM_W'(ARM_DLY - 1)) begin
              st      <= RUN;
              arm_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt + ARM_W'(1);
            end
          RUN:
            if (!sw_enable) st <= IDLE;
          FAULT:
            if (clr_ok) begin
              st          <= IDLE;
              fault_vec   <= '0;
              first_valid <= 1'b0;
              first_idx   <= '0;
            end
          default: st <= IDLE;
        endcase
      end
    end
  end

`ifdef ESC_FAULT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] fault_ts_q;

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      ts_cnt     <= '0;
      fault_ts_q <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trip_any && !first_valid)
        fault_ts_q <= ts_cnt;
      else if (clr_ok)
        fault_ts_q <= '0;
    end
  end

  assign fault_ts = fault_ts_q;
`else
  assign fault_ts = '0;
`endif

  assign state         = st;
  assign fault_latched = (st == FAULT);
  assign run_en        = (st == RUN) && !trip_any;
endmodule

// File: tb/tb_esc_fault_supervisor.sv
// Directed bench for esc_fault_supervisor at default parameters.
module tb_esc_fault_supervisor;
  logic       clk_ctrl = 1'b0;
  logic       rst_ctrl = 1'b0;
  logic [7:0] trip_raw = '0;
  logic [7:0] trip_mask = 8'hFF;
  logic       sw_enable = 1'b0;
  logic       sw_clear_fault = 1'b0;
  logic       run_en, fault_latched, first_valid;
  logic [7:0] fault_vec;
  logic [2:0] first_idx;
  logic [1:0] state;
  logic [31:0] fault_ts;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  esc_fault_supervisor dut (
    .clk_ctrl       (clk_ctrl),
    .rst_ctrl       (rst_ctrl),
    .trip_raw       (trip_raw),
    .trip_mask      (trip_mask),
    .sw_enable      (sw_enable),
    .sw_clear_fault (sw_clear_fault),
    .run_en         (run_en),
    .fault_latched  (fault_latched),
    .fault_vec      (fault_vec),
    .first_idx      (first_idx),
    .first_valid    (first_valid),
    .state          (state),
    .fault_ts       (fault_ts)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  always @(posedge clk_ctrl or posedge rst_ctrl)
    if (rst_ctrl) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ctrl);
    #1;
  endtask

  task automatic arm_to_run();
    sw_enable = 1'b0; tick(1);
    sw_enable = 1'b1; tick(17);
    tests++;
    if (state !== 2'd2 || run_en !== 1'b1) begin
      fails++; $display("FAIL arm_to_run state=%0d run_en=%b want 2/1", state, run_en);
    end
  endtask

  task automatic clear_pulse();
    sw_clear_fault = 1'b1; tick(1);
    sw_clear_fault = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_ctrl = 1'b1;
    #2;
    tests++;
    if ({run_en, fault_latched, fault_vec, first_idx, first_valid, state, fault_ts} !== '0) begin
      fails++;
      $display("FAIL reset run=%b fl=%b vec=%h idx=%0d fv=%b st=%0d ts=%0d want all 0",
               run_en, fault_latched, fault_vec, first_idx, first_valid, state, fault_ts);
    end
    @(negedge clk_ctrl) rst_ctrl = 1'b0;
    tick(2);
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL idle_after_reset state=%0d want 0", state); end
  endtask

  task automatic test_arm();
    sw_enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      tests++;
      if (state !== 2'd1 || run_en !== 1'b0) begin
        fails++; $display("FAIL arming k=%0d state=%0d run_en=%b want 1/0", k, state, run_en);
      end
    end
    tick(1);
    tests++;
    if (state !== 2'd2 || run_en !== 1'b1) begin
      fails++; $display("FAIL arm_done state=%0d run_en=%b want 2/1", state, run_en);
    end
  endtask

  task automatic test_glitch();
    trip_raw[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 3) trip_raw[2] = 1'b0;
      tests++;
      if (state !== 2'd2 || run_en !== 1'b1) begin
        fails++; $display("FAIL glitch3 k=%0d state=%0d run_en=%b want 2/1", k, state, run_en);
      end
    end
    trip_raw[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      tests++;
      if (run_en !== 1'b1) begin fails++; $display("FAIL trip_lat k=%0d run_en=%b want 1", k, run_en); end
    end
    tick(1);
    tests++;
    if (run_en !== 1'b0 || state !== 2'd2) begin
      fails++; $display("FAIL trip_fall run_en=%b state=%0d want 0/2", run_en, state);
    end
    tick(1);
    tests++;
    if (state !== 2'd3 || fault_vec !== 8'h04 || first_idx !== 3'd2 || first_valid !== 1'b1 || fault_latched !== 1'b1) begin
      fails++; $display("FAIL trip_fault st=%0d vec=%h idx=%0d fv=%b fl=%b want 3/04/2/1/1",
                        state, fault_vec, first_idx, first_valid, fault_latched);
    end
  endtask

  task automatic test_clear();
    sw_clear_fault = 1'b1; tick(2);
    tests++;
    if (state !== 2'd3 || fault_vec !== 8'h04) begin
      fails++; $display("FAIL clear_while_trip state=%0d vec=%h want 3/04", state, fault_vec);
    end
    sw_clear_fault = 1'b0;
    trip_raw[2] = 1'b0;
    tick(2);
    tests++;
    if (state !== 2'd3) begin fails++; $display("FAIL clear_not_latched state=%0d want 3", state); end
    clear_pulse();
    tests++;
    if (state !== 2'd0 || fault_vec !== 8'h00 || first_valid !== 1'b0 || first_idx !== 3'd0) begin
      fails++; $display("FAIL clear_ok st=%0d vec=%h fv=%b idx=%0d want 0/00/0/0",
                        state, fault_vec, first_valid, first_idx);
    end
    tick(4);
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL no_rearm_held state=%0d want 0", state); end
    sw_enable = 1'b0; tick(1);
    sw_enable = 1'b1; tick(1);
    tests++;
    if (state !== 2'd1) begin fails++; $display("FAIL rearm_edge state=%0d want 1", state); end
    tick(16);
    tests++;
    if (state !== 2'd2 || run_en !== 1'b1) begin
      fails++; $display("FAIL rearm_run state=%0d run_en=%b want 2/1", state, run_en);
    end
  endtask

  task automatic test_simultaneous();
    trip_raw = 8'h22; tick(5);
    tests++;
    if (run_en !== 1'b0) begin fails++; $display("FAIL simul_fall run_en=%b want 0", run_en); end
    tick(1);
    tests++;
    if (state !== 2'd3 || fault_vec !== 8'h22 || first_idx !== 3'd1) begin
      fails++; $display("FAIL simul_first st=%0d vec=%h idx=%0d want 3/22/1", state, fault_vec, first_idx);
    end
    trip_raw = 8'hA2; tick(6);
    tests++;
    if (fault_vec !== 8'hA2 || first_idx !== 3'd1 || state !== 2'd3) begin
      fails++; $display("FAIL simul_later vec=%h idx=%0d st=%0d want A2/1/3", fault_vec, first_idx, state);
    end
    trip_raw = 8'h00; tick(2);
    clear_pulse();
    tests++;
    if (state !== 2'd0 || fault_vec !== 8'h00) begin
      fails++; $display("FAIL simul_clear st=%0d vec=%h want 0/00", state, fault_vec);
    end
  endtask

  task automatic test_mask();
    arm_to_run();
    trip_mask = 8'hF7;
    trip_raw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      tests++;
      if (run_en !== 1'b1 || state !== 2'd2) begin
        fails++; $display("FAIL masked k=%0d run_en=%b state=%0d want 1/2", k, run_en, state);
      end
    end
    trip_mask = 8'hFF; tick(2);
    trip_mask = 8'hF7; tick(1);
    trip_mask = 8'hFF; tick(2);
    tests++;
    if (run_en !== 1'b1) begin fails++; $display("FAIL mask_restart run_en=%b want 1", run_en); end
    tick(1);
    tests++;
    if (run_en !== 1'b0) begin fails++; $display("FAIL mask_qual run_en=%b want 0", run_en); end
    tick(1);
    tests++;
    if (fault_vec !== 8'h08 || first_idx !== 3'd3 || state !== 2'd3) begin
      fails++; $display("FAIL mask_fault vec=%h idx=%0d st=%0d want 08/3/3", fault_vec, first_idx, state);
    end
    trip_mask = 8'hF7; tick(1);
    tests++;
    if (fault_vec !== 8'h08 || state !== 2'd3) begin
      fails++; $display("FAIL mask_sticky vec=%h st=%0d want 08/3", fault_vec, state);
    end
    trip_raw[3] = 1'b0; tick(3);
    trip_mask = 8'hFF;
    clear_pulse();
    tests++;
    if (state !== 2'd0 || fault_vec !== 8'h00) begin
      fails++; $display("FAIL mask_clear st=%0d vec=%h want 0/00", state, fault_vec);
    end
  endtask

  task automatic test_reset_midrun();
    arm_to_run();
    #2 rst_ctrl = 1'b1;
    #1;
    tests++;
    if (run_en !== 1'b0 || state !== 2'd0 || fault_vec !== 8'h00) begin
      fails++; $display("FAIL async_reset run_en=%b state=%0d vec=%h want 0/0/00", run_en, state, fault_vec);
    end
    sw_enable = 1'b0;
    @(negedge clk_ctrl) rst_ctrl = 1'b0;
    tick(2);
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL post_reset state=%0d want 0", state); end
  endtask

  task automatic test_timestamp();
    while (cyc < 1000) tick(1);
    trip_raw[0] = 1'b1;
    tick(5);
    tests++;
    if (fault_latched !== 1'b0 || state !== 2'd0) begin
      fails++; $display("FAIL idle_trip_early fl=%b st=%0d want 0/0", fault_latched, state);
    end
    tick(1);
    tests++;
    if (state !== 2'd3 || fault_vec !== 8'h01 || first_idx !== 3'd0 || first_valid !== 1'b1) begin
      fails++; $display("FAIL idle_trip st=%0d vec=%h idx=%0d fv=%b want 3/01/0/1",
                        state, fault_vec, first_idx, first_valid);
    end
    tests++;
`ifdef ESC_FAULT_TIMESTAMP_EN
    if (fault_ts !== 32'd1005) begin fails++; $display("FAIL ts_capture ts=%0d want 1005", fault_ts); end
`else
    if (fault_ts !== 32'd0) begin fails++; $display("FAIL ts_tied ts=%0d want 0", fault_ts); end
`endif
    trip_raw[0] = 1'b0; tick(2);
    clear_pulse();
    tests++;
    if (fault_ts !== 32'd0 || first_valid !== 1'b0 || state !== 2'd0) begin
      fails++; $display("FAIL ts_clear ts=%0d fv=%b st=%0d want 0/0/0", fault_ts, first_valid, state);
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_glitch();
    test_clear();
    test_simultaneous();
    test_mask();
    test_reset_midrun();
    test_timestamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
